// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the external SRAM port arbiter: FSM state
// encoding, port-select type and the minimum legal access length.
package sram_port_arbiter_pkg;

  // FSM state encoding (IDLE -> ACCESS -> TURN -> IDLE)
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_TURN   = 2'd2;

  // Which requester owns the access currently in flight
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_e;

  // An access needs one setup cycle, at least one strobe cycle and one hold cycle
  localparam int ACC_CYCLES_MIN = 3;

endpackage : sram_port_arbiter_pkg

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of a 512Kx8 asynchronous SRAM.
// Port A (Oric core, 64 KB window) and port B (bulk loader, full 19-bit
// space) take turns; every access runs ACC_CYCLES cycles with address and
// data held stable, the write strobe kept away from both ends of the access,
// and is followed by a one-cycle turnaround so requesters can drop req.
// All pin-facing outputs are registered so sram_we_n cannot glitch.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int         ACC_CYCLES = 4,
  parameter logic [2:0] A_BASE     = 3'b000,
  parameter int         STARVE_MAX = 8
) (
  input  logic        clk_sys,
  input  logic        reset,
  // port A: Oric core
  input  logic        a_req,
  input  logic        a_we,
  input  logic [15:0] a_addr,
  input  logic [7:0]  a_d,
  output logic [7:0]  a_q,
  output logic        a_ack,
  // port B: bulk loader
  input  logic        b_req,
  input  logic        b_we,
  input  logic [18:0] b_addr,
  input  logic [7:0]  b_d,
  output logic [7:0]  b_q,
  output logic        b_ack,
  // SRAM pins
  output logic [18:0] sram_a,
  output logic        sram_we_n,
  output logic [7:0]  sram_dout,
  output logic        sram_drive,
  input  logic [7:0]  sram_din,
  // status
  output logic        busy_b
);

  localparam int CW = $clog2(ACC_CYCLES);
  localparam int SW = $clog2(STARVE_MAX + 1);

  localparam logic [CW-1:0] CNT_LAST        = CW'(ACC_CYCLES - 1);
  localparam logic [CW-1:0] CNT_STROBE_LAST = CW'(ACC_CYCLES - 2);
  localparam logic [SW-1:0] STARVE_LIM      = SW'(STARVE_MAX);

  if (ACC_CYCLES < ACC_CYCLES_MIN) begin : g_bad_acc_cycles
    $error("sram_port_arbiter: ACC_CYCLES must be at least %0d", ACC_CYCLES_MIN);
  end

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] starve_cnt;
  port_sel_e     grant;
  logic          wr;

  logic          b_wins;
  logic [CW-1:0] cnt_next;
  logic          strobe_next;

  // Arbitration decision and next-cycle write-strobe qualification
  always_comb begin
    // NOTE: every always_comb output is assigned on every path here, so no
    // latch can be inferred; add a default first if a branch is ever added.
    b_wins      = b_req && (!a_req || (starve_cnt == STARVE_LIM));
    cnt_next    = cnt + 1'b1;
    // cnt_next is never 0 while counting, so only the upper bound matters
    strobe_next = wr && (cnt_next <= CNT_STROBE_LAST);
  end

  // Access sequencer: grant, timed SRAM pin control, read capture and ack
  always_ff @(posedge clk_sys) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      starve_cnt <= '0;
      grant      <= PORT_A;
      wr         <= 1'b0;
      sram_a     <= '0;
      sram_we_n  <= 1'b1;
      sram_dout  <= '0;
      sram_drive <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      busy_b     <= 1'b0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;

      case (state)
        ST_IDLE: begin
          sram_we_n  <= 1'b1;
          sram_drive <= 1'b0;
          if (a_req || b_req) begin
            state <= ST_ACCESS;
            cnt   <= '0;
            if (b_wins) begin
              grant      <= PORT_B;
              wr         <= b_we;
              sram_a     <= b_addr;
              sram_dout  <= b_d;
              sram_drive <= b_we;
              busy_b     <= 1'b1;
              starve_cnt <= '0;
            end else begin
              grant      <= PORT_A;
              wr         <= a_we;
              sram_a     <= {A_BASE, a_addr};
              sram_dout  <= a_d;
              sram_drive <= a_we;
              if (!b_req) begin
                starve_cnt <= '0;
              end else if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 1'b1;
              end
            end
          end
        end

        ST_ACCESS: begin
          if (cnt == CNT_LAST) begin
            state      <= ST_TURN;
            sram_we_n  <= 1'b1;
            sram_drive <= 1'b0;
            busy_b     <= 1'b0;
            if (grant == PORT_A) begin
              a_ack <= 1'b1;
              if (!wr) a_q <= sram_din;
            end else begin
              b_ack <= 1'b1;
              if (!wr) b_q <= sram_din;
            end
          end else begin
            cnt       <= cnt_next;
            sram_we_n <= !strobe_next;
          end
        end

        ST_TURN: begin
          state      <= ST_IDLE;
          sram_we_n  <= 1'b1;
          sram_drive <= 1'b0;
        end

        default: begin
          state      <= ST_IDLE;
          sram_we_n  <= 1'b1;
          sram_drive <= 1'b0;
        end
      endcase
    end
  end

endmodule : sram_port_arbiter

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter with a behavioural async SRAM
// (10 ns read delay). Directed vectors come from a table; multi-cycle corner
// cases are hand-written sequences. Expected read data and addresses are
// queued per port when a request is driven and checked when its ack appears.
module tb_sram_port_arbiter;
  import sram_port_arbiter_pkg::*;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [15:0] a_addr;
  logic [7:0]  a_d, b_d;
  logic [18:0] b_addr;
  logic [7:0]  a_q, b_q;
  logic        a_ack, b_ack;
  logic [18:0] sram_a;
  logic        sram_we_n, sram_drive;
  logic [7:0]  sram_dout, sram_din;
  logic        busy_b;

  int checks = 0;
  int errors = 0;

  always #10 clk_sys = ~clk_sys;

  sram_port_arbiter #(
    .ACC_CYCLES(4),
    .A_BASE    (3'b000),
    .STARVE_MAX(8)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_d       (a_d),
    .a_q       (a_q),
    .a_ack     (a_ack),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_d       (b_d),
    .b_q       (b_q),
    .b_ack     (b_ack),
    .sram_a    (sram_a),
    .sram_we_n (sram_we_n),
    .sram_dout (sram_dout),
    .sram_drive(sram_drive),
    .sram_din  (sram_din),
    .busy_b    (busy_b)
  );

  // Behavioural SRAM: writes while strobed and driven, reads 10 ns after address/we change
  logic [7:0] mem [0:(1<<19)-1];
  always @(negedge clk_sys) if (!sram_we_n && sram_drive) mem[sram_a] <= sram_dout;
  always @(sram_a or sram_we_n) sram_din <= #10 mem[sram_a];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard
  typedef struct {
    logic        rd;
    logic [7:0]  q;
    logic [18:0] sa;
  } exp_t;

  exp_t      qa[$];
  exp_t      qb[$];
  port_sel_e ack_log[$];
  logic [7:0] model_a_q = 8'h00;
  logic [7:0] model_b_q = 8'h00;

  // Ack monitor: pop the oldest expectation for the acking port and compare
  always @(negedge clk_sys) begin
    exp_t e;
    if (a_ack) begin
      ack_log.push_back(PORT_A);
      check("b_q_held_at_a_ack", b_q, model_b_q);
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_ack_unexpected: got ack, expected none pending");
      end else begin
        e = qa.pop_front();
        check("a_sram_a", sram_a, e.sa);
        if (e.rd) model_a_q = e.q;
        check("a_q", a_q, model_a_q);
      end
    end
    if (b_ack) begin
      ack_log.push_back(PORT_B);
      check("a_q_held_at_b_ack", a_q, model_a_q);
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_ack_unexpected: got ack, expected none pending");
      end else begin
        e = qb.pop_front();
        check("b_sram_a", sram_a, e.sa);
        if (e.rd) model_b_q = e.q;
        check("b_q", b_q, model_b_q);
      end
    end
  end

  // Single access from idle: checks latency and the per-cycle pin pattern
  task automatic access(input port_sel_e p, input logic we, input logic [18:0] addr,
                        input logic [7:0] d, input logic drop_early,
                        input logic [7:0] exp_q, input logic [18:0] exp_sa);
    logic [3:0] we_sig, drv_sig, busy_sig;
    int lat;
    exp_t e;
    we_sig = '1; drv_sig = '0; busy_sig = '0; lat = 0;
    e = '{rd: !we, q: exp_q, sa: exp_sa};
    if (p == PORT_A) qa.push_back(e); else qb.push_back(e);
    @(posedge clk_sys); #1;
    if (p == PORT_A) begin
      a_req = 1'b1; a_we = we; a_addr = addr[15:0]; a_d = d;
    end else begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_d = d;
    end
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk_sys);
      if (i >= 2 && i <= 5) begin
        we_sig[i-2]   = sram_we_n;
        drv_sig[i-2]  = sram_drive;
        busy_sig[i-2] = busy_b;
      end
      if ((p == PORT_A) ? a_ack : b_ack) begin
        lat = i - 1;
        break;
      end
      if (drop_early && i == 2) begin
        a_req = 1'b0;
        b_req = 1'b0;
      end
    end
    check("ack_latency", lat, 5);
    check("we_n_pattern", we_sig, we ? 4'b1001 : 4'b1111);
    check("drive_pattern", drv_sig, we ? 4'b1111 : 4'b0000);
    check("busy_b_pattern", busy_sig, (p == PORT_B) ? 4'b1111 : 4'b0000);
    if (lat == 0) begin
      qa.delete();
      qb.delete();
    end
    // Hold req through the TURN cycle; it must be ignored there
    @(posedge clk_sys); #1;
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  typedef struct {
    port_sel_e   port;
    logic        we;
    logic [18:0] addr;
    logic [7:0]  d;
    logic        drop_early;
    logic [7:0]  exp_q;
    logic [18:0] exp_sa;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] obs, expv;
    int n_acks;

    vecs[0]  = '{PORT_A, 1'b1, 19'h01234, 8'hA5, 1'b0, 8'h00, 19'h01234};
    vecs[1]  = '{PORT_A, 1'b0, 19'h01234, 8'h00, 1'b0, 8'hA5, 19'h01234};
    vecs[2]  = '{PORT_B, 1'b1, 19'h58000, 8'h3C, 1'b0, 8'h00, 19'h58000};
    vecs[3]  = '{PORT_B, 1'b0, 19'h58000, 8'h00, 1'b0, 8'h3C, 19'h58000};
    vecs[4]  = '{PORT_B, 1'b1, 19'h0ABCD, 8'h77, 1'b0, 8'h00, 19'h0ABCD};
    vecs[5]  = '{PORT_A, 1'b0, 19'h0ABCD, 8'h00, 1'b0, 8'h77, 19'h0ABCD};
    vecs[6]  = '{PORT_A, 1'b1, 19'h0FFFF, 8'hC3, 1'b0, 8'h00, 19'h0FFFF};
    vecs[7]  = '{PORT_B, 1'b0, 19'h0FFFF, 8'h00, 1'b0, 8'hC3, 19'h0FFFF};
    vecs[8]  = '{PORT_B, 1'b1, 19'h7FFFF, 8'hE1, 1'b0, 8'h00, 19'h7FFFF};
    vecs[9]  = '{PORT_B, 1'b0, 19'h7FFFF, 8'h00, 1'b0, 8'hE1, 19'h7FFFF};
    vecs[10] = '{PORT_A, 1'b1, 19'h00000, 8'h11, 1'b1, 8'h00, 19'h00000};
    vecs[11] = '{PORT_A, 1'b0, 19'h00000, 8'h00, 1'b1, 8'h11, 19'h00000};

    reset = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_d = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_d = '0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check("rst_we_n", sram_we_n, 1'b1);
    check("rst_drive", sram_drive, 1'b0);
    check("rst_sram_a", sram_a, 19'h0);
    check("rst_sram_dout", sram_dout, 8'h0);
    check("rst_acks", {a_ack, b_ack}, 2'b00);
    check("rst_a_q", a_q, 8'h0);
    check("rst_b_q", b_q, 8'h0);
    check("rst_busy_b", busy_b, 1'b0);
    reset = 1'b0;

    // Directed vectors, one access at a time from idle
    for (int v = 0; v < 12; v++) begin
      access(vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].d,
             vecs[v].drop_early, vecs[v].exp_q, vecs[v].exp_sa);
    end
    repeat (12) @(posedge clk_sys);
    @(negedge clk_sys); #1;
    check("no_duplicate_accesses", ack_log.size(), 12);

    // Both requests held continuously: 8 A grants, then B forced, repeating
    ack_log.delete();
    for (int k = 0; k < 16; k++) qa.push_back('{rd: 1'b1, q: 8'hA5, sa: 19'h01234});
    for (int k = 0; k < 2; k++)  qb.push_back('{rd: 1'b1, q: 8'h3C, sa: 19'h58000});
    @(posedge clk_sys); #1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 16'h1234;
    b_req = 1'b1; b_we = 1'b0; b_addr = 19'h58000;
    for (int i = 0; i < 400 && ack_log.size() < 18; i++) begin
      @(negedge clk_sys); #1;
    end
    @(posedge clk_sys); #1;
    a_req = 1'b0;
    b_req = 1'b0;
    check("starve_grant_count", ack_log.size(), 18);
    if (ack_log.size() >= 18) begin
      for (int k = 0; k < 18; k++) begin
        obs[k]  = (ack_log[k] == PORT_B);
        expv[k] = ((k % 9) == 8);
      end
      check("starve_grant_pattern", obs, expv);
    end
    repeat (12) @(posedge clk_sys);
    @(negedge clk_sys); #1;
    check("starve_no_extra_grant", ack_log.size(), 18);

    // Simultaneous first requests: A first, then B once A drops req
    ack_log.delete();
    qa.push_back('{rd: 1'b1, q: 8'h77, sa: 19'h0ABCD});
    qb.push_back('{rd: 1'b1, q: 8'hE1, sa: 19'h7FFFF});
    @(posedge clk_sys); #1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 16'hABCD;
    b_req = 1'b1; b_we = 1'b0; b_addr = 19'h7FFFF;
    for (int i = 0; i < 20 && ack_log.size() < 1; i++) begin
      @(negedge clk_sys); #1;
    end
    @(posedge clk_sys); #1;
    a_req = 1'b0;
    for (int i = 0; i < 20 && ack_log.size() < 2; i++) begin
      @(negedge clk_sys); #1;
    end
    @(posedge clk_sys); #1;
    b_req = 1'b0;
    check("simul_ack_count", ack_log.size(), 2);
    if (ack_log.size() >= 2) begin
      check("simul_first_grant", ack_log[0], PORT_A);
      check("simul_second_grant", ack_log[1], PORT_B);
    end

    // Reset during counter 1 of a write aborts at once with no ack
    repeat (2) @(posedge clk_sys);
    ack_log.delete();
    @(posedge clk_sys); #1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 16'h4444; a_d = 8'h99;
    repeat (3) @(negedge clk_sys);
    check("abort_we_n_low_before_reset", sram_we_n, 1'b0);
    reset = 1'b1;
    a_req = 1'b0;
    model_a_q = 8'h00;
    model_b_q = 8'h00;
    @(negedge clk_sys);
    check("abort_we_n", sram_we_n, 1'b1);
    check("abort_drive", sram_drive, 1'b0);
    check("abort_sram_a", sram_a, 19'h0);
    check("abort_a_q", a_q, 8'h0);
    reset = 1'b0;
    n_acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_sys);
      if (a_ack || b_ack) n_acks++;
    end
    check("abort_no_ack", n_acks, 0);
    // A fresh access after the abort must start from IDLE with normal latency
    access(PORT_A, 1'b0, 19'h01234, 8'h00, 1'b0, 8'hA5, 19'h01234);

    repeat (4) @(posedge clk_sys);
    check("scoreboard_a_empty", qa.size(), 0);
    check("scoreboard_b_empty", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sram_port_arbiter
